pili_seq: RTL and testbench

PILI_SEQ -- requirements
Module: pili_seq

---
 rtl/pili_seq.sv | 159 +++++++++++++++
 tb/tb_pili_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pili_seq.sv
// pili_seq: lamp chaser sequencer.
//   A prescaler divides the clock down to a pattern tick. On each tick the
//   position/direction state advances according to the last applied mode.
//   Lamps are decoded from that state one cycle later.
//
// Ports:
//   Clk   in   system clock, rising edge
//   Clr   in   asynchronous active-high reset
//   En    in   run enable; low freezes prescaler and pattern
//   Mode  in   00 bounce, 01 rotate-left, 10 rotate-right, 11 fill/drain bar
//   Div   in   step period minus one, in clock cycles
//   Lamp  out  registered lamp drive, bit 0 = leftmost lamp
//   Pos   out  position index (modes 00-10) or bar length (mode 11)
//   Dir   out  1 = up / bar growing, 0 = down
//   Step  out  one-cycle pulse following each tick-driven state update
//
// Mode table (LastMode selects the pattern; a mode change costs one tick):
//   mode | meaning
//   00   | bounce: 0..N-1..0, end lamps not repeated, period 2N-2 ticks
//   01   | rotate-left: Pos+1, N-1 wraps to 0, Dir held 1
//   10   | rotate-right: Pos-1, 0 wraps to N-1, Dir held 0
//   11   | fill/drain: bar length 0..N..0, period 2N ticks

module pili_seq #(
  parameter int N  = 6,
  parameter int PW = 4,
  parameter int DW = 4
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          En,
  input  logic [1:0]    Mode,
  input  logic [DW-1:0] Div,
  output logic [N-1:0]  Lamp,
  output logic [PW-1:0] Pos,
  output logic          Dir,
  output logic          Step
);

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROTL   = 2'b01;
  localparam logic [1:0] MODE_ROTR   = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  localparam logic [PW-1:0] POS_ZERO = '0;
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] POS_LAST = PW'(N - 1);
  localparam logic [PW-1:0] POS_TOP  = PW'(N);

  logic [DW-1:0] cnt;
  logic          tick;
  logic [1:0]    last_mode;
  logic [PW-1:0] pos_next;
  logic          dir_next;
  logic [N-1:0]  lamp_next;

  // Exact compare only: if Div is lowered below the running count, the
  // counter runs on through its full range and wraps without ticking.
  assign tick = En && (cnt == Div);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      cnt <= '0;
    end else if (En) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + DW'(1);
    end
  end

  // Next position/direction for an advance in the current pattern.
  // The >= / > guards keep Pos inside its legal range even from a stale
  // value left over by a different mode.
  always_comb begin
    pos_next = Pos;
    dir_next = Dir;
    case (last_mode)
      MODE_BOUNCE: begin
        if (Dir) begin
          if (Pos >= POS_LAST) begin
            pos_next = POS_LAST - POS_ONE;
            dir_next = 1'b0;
          end else begin
            pos_next = Pos + POS_ONE;
          end
        end else begin
          if (Pos == POS_ZERO) begin
            pos_next = POS_ONE;
            dir_next = 1'b1;
          end else begin
            pos_next = Pos - POS_ONE;
          end
        end
      end
      MODE_ROTL: begin
        pos_next = (Pos >= POS_LAST) ? POS_ZERO : Pos + POS_ONE;
        dir_next = 1'b1;
      end
      MODE_ROTR: begin
        pos_next = (Pos == POS_ZERO || Pos > POS_LAST) ? POS_LAST : Pos - POS_ONE;
        dir_next = 1'b0;
      end
      default: begin
        if (Dir) begin
          if (Pos >= POS_TOP) begin
            pos_next = POS_TOP - POS_ONE;
            dir_next = 1'b0;
          end else begin
            pos_next = Pos + POS_ONE;
          end
        end else begin
          if (Pos == POS_ZERO) begin
            pos_next = POS_ONE;
            dir_next = 1'b1;
          end else begin
            pos_next = Pos - POS_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      Pos       <= '0;
      Dir       <= 1'b1;
      last_mode <= MODE_BOUNCE;
      Step      <= 1'b0;
    end else begin
      Step <= tick;
      if (tick) begin
        if (Mode != last_mode) begin
          // Mode change: reload only, the new pattern advances from the next tick.
          last_mode <= Mode;
          Pos       <= '0;
          Dir       <= 1'b1;
        end else begin
          Pos <= pos_next;
          Dir <= dir_next;
        end
      end
    end
  end

  // Decode uses last_mode so the lamps always match the pattern that
  // produced Pos, not a Mode input that has not yet been applied.
  always_comb begin
    lamp_next = '0;
    for (int i = 0; i < N; i++) begin
      if (last_mode == MODE_FILL) lamp_next[i] = (PW'(i) < Pos);
      else                        lamp_next[i] = (PW'(i) == Pos);
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) Lamp <= '0;
    else     Lamp <= lamp_next;
  end

endmodule

// File: tb/tb_pili_seq.sv
module tb_pili_seq;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       En;
  logic [1:0] Mode;
  logic [3:0] Div;
  logic [5:0] Lamp;
  logic [3:0] Pos;
  logic       Dir;
  logic       Step;

  int vectors = 0;
  int miscompares = 0;

  pili_seq #(.N(6), .PW(4), .DW(4)) dut (
    .Clk  (Clk),
    .Clr  (Clr),
    .En   (En),
    .Mode (Mode),
    .Div  (Div),
    .Lamp (Lamp),
    .Pos  (Pos),
    .Dir  (Dir),
    .Step (Step)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Clr = 1'b1;
    #2;
    Clr = 1'b0;
  endtask

  int bpos [13] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
  int bdir [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
  int rpos [8]  = '{0, 5, 4, 3, 2, 1, 0, 5};
  int lpos [8]  = '{0, 1, 2, 3, 4, 5, 0, 1};
  int fpos [14] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1};
  int fdir [14] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    Clr = 1'b1; En = 1'b0; Mode = 2'b00; Div = 4'd0;
    #3;
    chk("rst_lamp", 32'(Lamp), 32'd0);
    chk("rst_pos",  32'(Pos),  32'd0);
    chk("rst_dir",  32'(Dir),  32'd1);
    chk("rst_step", 32'(Step), 32'd0);
    cyc();
    chk("rst_lamp_clk", 32'(Lamp), 32'd0);

    // Bounce, Div=0
    En = 1'b1;
    Clr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("bounce_pos",  32'(Pos),  32'(bpos[k]));
      chk("bounce_dir",  32'(Dir),  32'(bdir[k]));
      chk("bounce_lamp", 32'(Lamp), 32'd1 << bpos[k-1]);
      chk("bounce_step", 32'(Step), 32'd1);
    end
    cyc();
    chk("pre_freeze_pos", 32'(Pos), 32'd3);

    // Freeze at Pos=3
    En = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("freeze_pos",  32'(Pos),  32'd3);
      chk("freeze_step", 32'(Step), 32'd0);
      chk("freeze_lamp", 32'(Lamp), 32'd8);
      chk("freeze_dir",  32'(Dir),  32'd1);
    end
    En = 1'b1;
    cyc();
    chk("resume_pos",  32'(Pos),  32'd4);
    chk("resume_step", 32'(Step), 32'd1);
    cyc();
    chk("sweep_pos5", 32'(Pos), 32'd5);
    cyc();
    chk("sweep_pos4", 32'(Pos), 32'd4);
    chk("sweep_dir0", 32'(Dir), 32'd0);

    // Short Clr pulse mid-sweep
    #2;
    Clr = 1'b1;
    #1;
    chk("clr_lamp", 32'(Lamp), 32'd0);
    chk("clr_pos",  32'(Pos),  32'd0);
    chk("clr_dir",  32'(Dir),  32'd1);
    chk("clr_step", 32'(Step), 32'd0);
    Clr = 1'b0;
    cyc();
    chk("restart_pos1",  32'(Pos),  32'd1);
    chk("restart_lamp1", 32'(Lamp), 32'd1);
    cyc();
    chk("restart_pos2",  32'(Pos),  32'd2);
    chk("restart_lamp2", 32'(Lamp), 32'd2);

    // Prescaler Div=3
    Div = 4'd3;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("div3_step", 32'(Step), 32'((k % 4) == 0));
      chk("div3_pos",  32'(Pos),  32'(k / 4));
    end

    // Rotate-right from reset
    Div = 4'd0;
    Mode = 2'b10;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("rotr_pos",  32'(Pos),  32'(rpos[k-1]));
      chk("rotr_dir",  32'(Dir),  32'(k == 1));
      chk("rotr_step", 32'(Step), 32'd1);
      chk("rotr_lamp", 32'(Lamp), (k == 1) ? 32'd1 : (32'd1 << rpos[k-2]));
    end

    // Rotate-left from reset
    Mode = 2'b01;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("rotl_pos",  32'(Pos),  32'(lpos[k-1]));
      chk("rotl_dir",  32'(Dir),  32'd1);
      chk("rotl_lamp", 32'(Lamp), (k == 1) ? 32'd1 : (32'd1 << lpos[k-2]));
    end

    // Fill/drain bar
    Mode = 2'b11;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      cyc();
      chk("fill_pos", 32'(Pos), 32'(fpos[k-1]));
      chk("fill_dir", 32'(Dir), 32'(fdir[k-1]));
      chk("fill_lamp", 32'(Lamp), (k == 1) ? 32'd1 : ((32'd1 << fpos[k-2]) - 32'd1));
    end

    // Div lowered below running count: wrap through 15 without a tick
    Mode = 2'b00;
    Div = 4'd7;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("div7_step", 32'(Step), 32'd0);
    end
    Div = 4'd2;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      chk("divwrap_step", 32'(Step), 32'(k == 14));
    end
    chk("divwrap_pos", 32'(Pos), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
